// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment score display.
`timescale 1ns/100ps
package seg_pkg;

  // All segments off (cathodes are active low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // All digit anodes off (anodes are active low).
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Four BCD digits; index 0 is the ones digit, index 3 the thousands digit.
  typedef logic [3:0][3:0] bcd4_t;

  // Digit to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational 14-bit binary to 4-digit BCD converter (shift-add-3).
`timescale 1ns/100ps
module bin2bcd
  import seg_pkg::*;
(
  input  logic [13:0] bin,
  output bcd4_t       bcd
);

  // Upper 16 bits accumulate BCD digits, lower 14 bits hold the binary being shifted in.
  logic [29:0] sh;

  // Double-dabble: before each shift, any digit >= 5 gets +3 so the shift carries correctly.
  always_comb begin
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14 + 4*d +: 4] >= 4'd5) begin
          sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
  end

  assign bcd = bcd4_t'(sh[29:14]);

endmodule

// File: rtl/seg_display.sv
// 4-digit common-anode multiplexed 7-segment display driver for a decimal score.
// The score is sampled every edge, clamped to 9999, converted to BCD, and one
// digit at a time is loaded into the anode/segment registers together.
`timescale 1ns/100ps
module seg_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 1
)(
  input  logic        segclk,
  input  logic        clr,
  input  logic [14:0] score,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [14:0]      score_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;
  logic             started_q;
  logic [13:0]      score_sat;
  bcd4_t            bcd;
  logic             tick;
  logic             load;
  logic [1:0]       idx_nxt;

  // Values above four decimal digits are shown as 9999.
  function automatic logic [13:0] sat_score(input logic [14:0] s);
    if (s > 15'd9999) return 14'd9999;
    else              return s[13:0];
  endfunction

  assign score_sat = sat_score(score_q);

  bin2bcd u_bin2bcd (
    .bin (score_sat),
    .bcd (bcd)
  );

  // The first edge after reset loads digit 0; after that a digit is loaded per tick.
  assign tick    = started_q && (div_q == DIV_LAST);
  assign load    = !started_q || tick;
  assign idx_nxt = started_q ? idx_q + 2'd1 : 2'd0;

  // Score sample register.
  always_ff @(posedge segclk or negedge clr) begin
    if (!clr) score_q <= '0;
    else      score_q <= score;
  end

  // Digit-period divider; idle until the first digit is loaded so every digit gets SCAN_DIV edges.
  always_ff @(posedge segclk or negedge clr) begin
    if (!clr) begin
      div_q <= '0;
    end else if (started_q) begin
      if (tick) div_q <= '0;
      else      div_q <= div_q + 1'b1;
    end
  end

  // Scan index and output registers; anode and segments update on the same edge.
  always_ff @(posedge segclk or negedge clr) begin
    if (!clr) begin
      started_q <= 1'b0;
      idx_q     <= 2'd0;
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
    end else if (load) begin
      started_q <= 1'b1;
      idx_q     <= idx_nxt;
      an        <= ~(4'b0001 << idx_nxt);
      seg       <= seg_decode(bcd[idx_nxt]);
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Randomized scoreboard bench for seg_display (SCAN_DIV = 1 and SCAN_DIV = 4 instances).
`timescale 1ns/100ps
module tb_seg_display;

  logic        segclk = 1'b0;
  logic        clr    = 1'b0;
  logic [14:0] score  = '0;
  logic [6:0]  seg1, seg4;
  logic [3:0]  an1,  an4;

  int n_cmp = 0;
  int n_bad = 0;

  // 2 ns scan clock.
  always #1 segclk = ~segclk;

  seg_display #(.SCAN_DIV(1)) dut1 (
    .segclk (segclk), .clr (clr), .score (score), .seg (seg1), .an (an1)
  );
  seg_display #(.SCAN_DIV(4)) dut4 (
    .segclk (segclk), .clr (clr), .score (score), .seg (seg4), .an (an4)
  );

  // Reference: segment pattern of each decimal digit, {g,f,e,d,c,b,a} active low.
  logic [6:0] dec_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  // Per-instance model state: shown digit, edges since it was loaded, last sampled score.
  bit         m_run [2];
  int         m_dig [2];
  int         m_age [2];
  int         m_sq  [2];
  logic [3:0] m_an  [2];
  logic [6:0] m_seg [2];

  logic [10:0] q1 [$];
  logic [10:0] q4 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model of one instance by one clock edge and return its expected {an, seg}.
  task automatic model_step(input int i, input int div, output logic [10:0] e);
    bit load;
    int shown, d;
    if (!clr) begin
      m_run[i] = 0;
      m_sq[i]  = 0;
      m_an[i]  = 4'hF;
      m_seg[i] = 7'h7F;
    end else begin
      load = 0;
      if (!m_run[i]) begin
        m_run[i] = 1; m_dig[i] = 0; m_age[i] = 0; load = 1;
      end else begin
        m_age[i]++;
        if (m_age[i] == div) begin
          m_age[i] = 0; m_dig[i] = (m_dig[i] + 1) % 4; load = 1;
        end
      end
      if (load) begin
        shown    = (m_sq[i] > 9999) ? 9999 : m_sq[i];
        d        = (shown / pow10[m_dig[i]]) % 10;
        m_an[i]  = 4'hF & ~(4'(1) << m_dig[i]);
        m_seg[i] = dec_tab[d];
      end
      m_sq[i] = int'(score);
    end
    e = {m_an[i], m_seg[i]};
  endtask

  // Stimulus side of the scoreboard: expected outputs after each edge are queued.
  always @(posedge segclk) begin
    logic [10:0] e;
    model_step(0, 1, e);
    q1.push_back(e);
    model_step(1, 4, e);
    q4.push_back(e);
  end

  // Monitor: compare DUT outputs shortly after each edge against the queued expectations.
  always @(posedge segclk) begin
    logic [10:0] e;
    #0.5;
    if (q1.size() == 0 || q4.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q1.pop_front();
      check("div1_an",  32'(an1),  32'(e[10:7]));
      check("div1_seg", 32'(seg1), 32'(e[6:0]));
      e = q4.pop_front();
      check("div4_an",  32'(an4),  32'(e[10:7]));
      check("div4_seg", 32'(seg4), 32'(e[6:0]));
      if (clr) begin
        check("div1_onehot", 32'($countones(~an1)), 32'd1);
        check("div4_onehot", 32'($countones(~an4)), 32'd1);
      end
    end
  end

  task automatic run_score(input logic [14:0] v, input int cycles);
    @(negedge segclk);
    score = v;
    repeat (cycles) @(negedge segclk);
  endtask

  initial begin
    bit found;
    logic [14:0] v;

    // Reset held with changing scores: display stays blank.
    clr = 1'b0;
    repeat (10) begin
      @(negedge segclk);
      score = 15'($urandom_range(0, 32767));
    end

    // Release with 2345: scan 5,4,3,2 repeating.
    @(negedge segclk);
    score = 15'd2345;
    @(negedge segclk);
    clr = 1'b1;
    repeat (24) @(negedge segclk);

    // Boundary scores.
    run_score(15'd0,     20);
    run_score(15'd9999,  20);
    run_score(15'd10000, 20);
    run_score(15'd32767, 20);
    run_score(15'd7,     20);

    // Mid-frame change.
    run_score(15'd2345, 9);
    run_score(15'd6789, 24);

    // Randomized scores with random hold times, biased toward the clamp boundary.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 15'($urandom_range(9990, 10010));
        1:       v = 15'($urandom_range(0, 99));
        default: v = 15'($urandom_range(0, 32767));
      endcase
      run_score(v, $urandom_range(1, 12));
    end

    // Reset while the hundreds digit is shown: blank immediately, restart at ones digit.
    score = 15'd4821;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge segclk);
      #0.5;
      if (an1 == 4'b1011) found = 1;
    end
    if (!found) check("wait_an_1011", 32'd0, 32'd1);
    #0.2;
    clr = 1'b0;
    #0.2;
    check("async_blank_an1",  32'(an1),  32'hF);
    check("async_blank_seg1", 32'(seg1), 32'h7F);
    check("async_blank_an4",  32'(an4),  32'hF);
    check("async_blank_seg4", 32'(seg4), 32'h7F);
    repeat (3) @(negedge segclk);
    clr = 1'b1;
    @(posedge segclk);
    #0.5;
    check("restart_an1", 32'(an1), 32'hE);
    check("restart_an4", 32'(an4), 32'hE);
    repeat (30) @(negedge segclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
